// File: rtl/idu_issue_q.sv
// Decode/issue queue: DEPTH-entry {pc, inst} FIFO with a per-register pending-write scoreboard.
// Optional macro IDU_WB_BYPASS_EN lets the hazard check see this cycle's writeback retire.
module idu_issue_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid_pre_i,
  output logic                     ready_pre_o,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              inst_i,
  output logic                     valid_post_o,
  input  logic                     ready_post_i,
  output logic [XLEN-1:0]          pc_o,
  output logic [31:0]              inst_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [4:0]               rd_o,
  output logic                     rd_wen_o,
  input  logic                     wb_retire_i,
  input  logic [4:0]               wb_rd_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0]              pc_q   [DEPTH];
  logic [31:0]                  inst_q [DEPTH];
  logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [NREG-1:0][CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;

  logic [31:0] head_inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        uses_rs1, uses_rs2, writes, rd_wen;
  logic        empty, full, hazard, enq, issue;

  // Register 0 is never tracked, so it always reads as zero pending writes.
  function automatic logic [CNT_W-1:0] cnt_at(input logic [NREG-1:0][CNT_W-1:0] v,
                                              input logic [4:0] r);
    cnt_at = '0;
    for (int i = 1; i < NREG; i++)
      if (r == 5'(i)) cnt_at = v[i];
  endfunction

  // Saturating up/down step; simultaneous inc and dec cancel.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    sat_step = c;
    if (inc && !dec && c != '1)      sat_step = c + 1'b1;
    else if (dec && !inc && c != '0) sat_step = c - 1'b1;
  endfunction

  assign head_inst = inst_q[rptr_q];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign pc_o      = pc_q[rptr_q];
  assign inst_o    = head_inst;
  assign rs1_o     = head_inst[19:15];
  assign rs2_o     = head_inst[24:20];
  assign rd_o      = head_inst[11:7];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    unique case (opcode)
      OP_LOAD, OP_OPIMM:  begin uses_rs1 = 1'b1; writes = 1'b1; end
      OP_STORE, OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_OP:              begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes = 1'b1; end
      OP_JALR:            begin uses_rs1 = 1'b1; writes = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: writes = 1'b1;
      OP_SYSTEM: begin
        uses_rs1 = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
        writes   = (funct3 != 3'd0);
      end
      default: ;
    endcase
  end

  assign rd_wen   = writes && (rd_o != 5'd0);
  assign rd_wen_o = rd_wen;

  always_comb begin
    cnt_eff = cnt_q;
`ifdef IDU_WB_BYPASS_EN
    for (int i = 1; i < NREG; i++)
      if (wb_retire_i && wb_rd_i == 5'(i) && cnt_q[i] != '0)
        cnt_eff[i] = cnt_q[i] - 1'b1;
`endif
  end

  assign hazard = (uses_rs1 && cnt_at(cnt_eff, rs1_o) != '0) ||
                  (uses_rs2 && cnt_at(cnt_eff, rs2_o) != '0) ||
                  (rd_wen   && cnt_at(cnt_eff, rd_o)  == '1);

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign ready_pre_o  = !full;
  assign valid_post_o = !empty && !hazard && !flush_i;
  assign stall_o      = !empty && hazard;
  assign count_o      = count_q;
  assign enq          = valid_pre_i && !full && !flush_i;
  assign issue        = valid_post_o && ready_post_i;

  always_comb begin
    wptr_d  = enq   ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = issue ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CW'(enq) - CW'(issue);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++)
      cnt_d[i] = sat_step(cnt_q[i], issue && rd_wen && rd_o == 5'(i),
                          wb_retire_i && wb_rd_i == 5'(i));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (enq) begin
      pc_q[wptr_q]   <= pc_i;
      inst_q[wptr_q] <= inst_i;
    end
  end

endmodule

// File: tb/tb_idu_issue_q.sv
// Directed bench for idu_issue_q: issue latency, RAW/WAW stalls, full queue, flush, scoreboard edge cases.
module tb_idu_issue_q;
  localparam int XLEN = 32, DEPTH = 2, NREG = 32, CNT_W = 2;

  localparam logic [31:0] ADDI1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD2  = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] LUI6  = 32'h00001337; // lui  x6,1
  localparam logic [31:0] LUI7  = 32'h000023B7; // lui  x7,2
  localparam logic [31:0] SW0   = 32'h00002023; // sw   x0,0(x0)
  localparam logic [31:0] ADDI5 = 32'h00000293; // addi x5,x0,0
  localparam logic [31:0] ADDI3 = 32'h00000193; // addi x3,x0,0
  localparam logic [31:0] RD3   = 32'h00018213; // addi x4,x3,0
  localparam logic [31:0] RD9   = 32'h00048513; // addi x10,x9,0

  logic clock = 1'b0, reset = 1'b1;
  logic valid_pre_i = 0, ready_post_i = 0, wb_retire_i = 0, flush_i = 0;
  logic [XLEN-1:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic [4:0] wb_rd_i = '0;
  logic ready_pre_o, valid_post_o, rd_wen_o, stall_o;
  logic [XLEN-1:0] pc_o;
  logic [31:0] inst_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [$clog2(DEPTH):0] count_o;

  int n_cmp = 0, n_bad = 0;

  idu_issue_q #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .pc_o(pc_o), .inst_o(inst_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .rd_wen_o(rd_wen_o), .wb_retire_i(wb_retire_i), .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .count_o(count_o), .stall_o(stall_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    valid_pre_i = 1'b1; pc_i = pc; inst_i = inst;
    step();
    valid_pre_i = 1'b0;
  endtask

  // Retire r while the head waits on it, then confirm the head issues.
  task automatic retire_release(input logic [4:0] r, input string tag);
    wb_retire_i = 1'b1; wb_rd_i = r;
    #1;
`ifdef IDU_WB_BYPASS_EN
    chk({tag, "_vpost_at_T"}, 64'(valid_post_o), 64'd1);
    step();
    chk({tag, "_issued"}, 64'(count_o), 64'd0);
    wb_retire_i = 1'b0; wb_rd_i = '0;
`else
    chk({tag, "_vpost_at_T"}, 64'(valid_post_o), 64'd0);
    step();
    chk({tag, "_vpost_T1"}, 64'(valid_post_o), 64'd1);
    wb_retire_i = 1'b0; wb_rd_i = '0;
    step();
    chk({tag, "_issued"}, 64'(count_o), 64'd0);
`endif
  endtask

  initial begin
    #12;
    chk("rst_ready_pre", 64'(ready_pre_o), 64'd1);
    chk("rst_valid_post", 64'(valid_post_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    reset = 1'b0;
    step();

    // Single writer, 1-cycle latency
    ready_post_i = 1'b1;
    push(32'h100, ADDI1);
    chk("t1_vpost", 64'(valid_post_o), 64'd1);
    chk("t1_rd", 64'(rd_o), 64'd1);
    chk("t1_rdwen", 64'(rd_wen_o), 64'd1);
    chk("t1_pc", 64'(pc_o), 64'h100);
    chk("t1_count", 64'(count_o), 64'd1);
    step();
    chk("t1_drained", 64'(count_o), 64'd0);

    // RAW on x1 (cnt[1]=1)
    push(32'h104, ADD2);
    chk("t2_stall", 64'(stall_o), 64'd1);
    chk("t2_vpost", 64'(valid_post_o), 64'd0);
    chk("t2_rs1", 64'(rs1_o), 64'd1);
    chk("t2_rs2", 64'(rs2_o), 64'd1);
    step();
    chk("t2_still_stall", 64'(stall_o), 64'd1);
    retire_release(5'd1, "t2");

    // Fill queue, no pass-through, in-order drain with wrap
    ready_post_i = 1'b0;
    push(32'h200, LUI6);
    push(32'h204, LUI7);
    chk("t3_count_full", 64'(count_o), 64'(DEPTH));
    chk("t3_ready_pre", 64'(ready_pre_o), 64'd0);
    push(32'h208, SW0);
    chk("t3_no_overflow", 64'(count_o), 64'(DEPTH));
    chk("t3_head_pc", 64'(pc_o), 64'h200);
    ready_post_i = 1'b1;
    #1;
    chk("t3_no_passthru", 64'(ready_pre_o), 64'd0);
    step();
    chk("t3_second_pc", 64'(pc_o), 64'h204);
    chk("t3_second_rd", 64'(rd_o), 64'd7);
    chk("t3_count1", 64'(count_o), 64'd1);
    step();
    chk("t3_empty", 64'(count_o), 64'd0);

    // Flush with two queued entries and a concurrent push
    ready_post_i = 1'b0;
    push(32'h300, SW0);
    push(32'h304, SW0);
    chk("t4_count2", 64'(count_o), 64'd2);
    flush_i = 1'b1; valid_pre_i = 1'b1; pc_i = 32'h308; inst_i = SW0;
    #1;
    chk("t4_vpost_in_flush", 64'(valid_post_o), 64'd0);
    step();
    flush_i = 1'b0; valid_pre_i = 1'b0;
    chk("t4_count0", 64'(count_o), 64'd0);
    chk("t4_vpost0", 64'(valid_post_o), 64'd0);
    chk("t4_ready_pre", 64'(ready_pre_o), 64'd1);
    push(32'h30C, SW0);
    chk("t4_dropped_pc", 64'(pc_o), 64'h30C);
    chk("t4_count1", 64'(count_o), 64'd1);
    ready_post_i = 1'b1;
    step();

    // WAW saturation on x5
    push(32'h400, ADDI5);
    push(32'h404, ADDI5);
    push(32'h408, ADDI5);
    push(32'h40C, ADDI5);
    chk("t5_stall", 64'(stall_o), 64'd1);
    chk("t5_count", 64'(count_o), 64'd1);
    step();
    chk("t5_hold_pc", 64'(pc_o), 64'h40C);
    retire_release(5'd5, "t5");

    // Issue and retire x3 in the same cycle leaves cnt[3] at 1
    push(32'h500, ADDI3);
    step();
    push(32'h504, ADDI3);
    chk("t6_vpost", 64'(valid_post_o), 64'd1);
    wb_retire_i = 1'b1; wb_rd_i = 5'd3;
    step();
    wb_retire_i = 1'b0; wb_rd_i = '0;
    chk("t6_issued", 64'(count_o), 64'd0);
    push(32'h508, RD3);
    chk("t6_reader_stall", 64'(stall_o), 64'd1);
    retire_release(5'd3, "t6");

    // Retire of x0 and of an idle register change nothing
    wb_retire_i = 1'b1; wb_rd_i = 5'd9;
    step();
    wb_rd_i = 5'd0;
    step();
    wb_retire_i = 1'b0;
    push(32'h600, RD9);
    chk("t7_no_stall", 64'(stall_o), 64'd0);
    chk("t7_vpost", 64'(valid_post_o), 64'd1);
    step();

    // Asynchronous reset mid-operation
    ready_post_i = 1'b0;
    push(32'h700, SW0);
    chk("t8_count1", 64'(count_o), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("t8_async_count", 64'(count_o), 64'd0);
    chk("t8_async_vpost", 64'(valid_post_o), 64'd0);
    chk("t8_async_ready", 64'(ready_pre_o), 64'd1);
    step();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
